store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffered store entries (power of two, 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-low (rst=0 resets).
REQ-004 st_valid  input  1  MEM stage presents a store this cycle.
REQ-005 st_addr  input  32  store byte address; word index = st_addr[31:2].
REQ-006 st_data  input  32  store word.
REQ-007 st_ready  output  1  buffer accepts the store this cycle.
REQ-008 ld_addr  input  32  MEM-stage load byte address.
REQ-009 ld_data  output  32  load result after forwarding.
REQ-010 mem_ready  input  1  data memory write port is free this cycle.
REQ-011 mem_write_en  output  1  drives the data memory writeEN.
REQ-012 mem_write_address  output  32  drives the data memory writeAddress.
REQ-013 mem_write_data  output  32  drives the data memory writeData.
REQ-014 mem_read_address  output  32  drives the data memory readAddress.
REQ-015 mem_read_data  input  32  data memory readData (combinational read).
REQ-016 count  output  $clog2(DEPTH)+1  occupied entries; empty/full outputs  1 bit each.

Function
REQ-017 Storage SHALL be a circular FIFO of {addr[31:0], data[31:0]} with head/tail pointers and a count register.
REQ-018 Push: when st_valid && st_ready, the store SHALL be written at tail on the rising edge; tail advances mod DEPTH.
REQ-019 st_ready SHALL be !full || drain, where drain = mem_ready && !empty; push into a full buffer is allowed only when a pop occurs in the same cycle.
REQ-020 Drain: mem_write_en = !empty && mem_ready && rst; mem_write_address/mem_write_data = head entry, combinational; head advances on the same edge.
REQ-021 Stores SHALL reach memory in program order, one per cycle at most; latency push-to-memory-write is at least 1 cycle.
REQ-022 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-023 Pointer wrap-around at DEPTH-1 -> 0 SHALL be seamless; full = (count==DEPTH), empty = (count==0).
REQ-024 mem_read_address SHALL equal ld_addr (pass-through).
REQ-025 Forwarding: ld_data SHALL be the data of the youngest valid entry whose addr[31:2] equals ld_addr[31:2], else mem_read_data; purely combinational.
REQ-026 Forwarding SHALL consider entries held at the start of the cycle, including the head being drained; the store being pushed in the same cycle SHALL NOT forward.
REQ-027 Address bits [1:0] SHALL be ignored in every comparison; only whole-word stores are supported.
REQ-028 st_valid while not ready SHALL be dropped by this block; the pipeline holds the store (stall) until st_ready.

Reset
REQ-029 While rst=0: head=tail=count=0, all entry valid state cleared, mem_write_en=0, st_ready=0, empty=1, full=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered stores without writing them to memory.
REQ-031 Entry data/address registers need not be reset; ld_data during reset SHALL equal mem_read_data.

Structure
REQ-032 Package mem_pkg SHALL hold the store-entry struct type (addr, data) and the WORD_ADDR_LSB=2 constant.
REQ-033 One sub-module, sb_forward_match, SHALL implement the youngest-match priority search over DEPTH entries, returning hit and data.
REQ-034 The block SHALL sit between the MEM pipeline stage and the data memory, owning its write port exclusively.

Verification
REQ-035 Single store: push addr 0x10, data 0xDEADBEEF with mem_ready=1 -> next cycle mem_write_en=1, address 0x10, data 0xDEADBEEF; count returns to 0.
REQ-036 Fill: mem_ready=0, push 4 stores to 0x00,0x04,0x08,0x0C -> full=1, st_ready=0; raise mem_ready -> writes drain in order, one per cycle.
REQ-037 Forwarding: buffer holds 0x20<-0x11, then 0x20<-0x22 (mem_ready=0), load 0x22 (same word) -> ld_data=0x22; load 0x24 -> ld_data=mem_read_data.
REQ-038 Full with drain: full buffer, mem_ready=1, st_valid=1 -> st_ready=1, count stays 4, wrap of tail 3->0 observed.
REQ-039 Same-cycle push/load: empty buffer, push 0x30<-0x55 and load 0x30 same cycle -> ld_data=mem_read_data (not 0x55).
REQ-040 Reset mid-drain: 3 entries, mem_ready=0, drive rst=0 one cycle -> count=0, no memory write occurs afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory store path.
// Word granularity comparison lives here so every block ignores the byte offset identically.
package mem_pkg;

  localparam int WORD_ADDR_LSB = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_entry_t;

  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:WORD_ADDR_LSB] == b[31:WORD_ADDR_LSB];
  endfunction

endpackage

// File: rtl/sb_forward_match.sv
// Youngest-match search over buffered stores; entries arrive ordered oldest (0) to youngest.
// Later matches overwrite earlier ones, so the youngest live entry wins.
module sb_forward_match
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  store_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]         valid,
  input  logic [31:0]              addr,
  output logic                     hit,
  output logic [31:0]              data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && same_word(entries[i].addr, addr)) begin
        hit  = 1'b1;
        data = entries[i].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and data memory: drains in program order
// through the memory write port and forwards buffered data to same-word loads.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_ready,
  input  logic [31:0]              ld_addr,
  output logic [31:0]              ld_data,
  input  logic                     mem_ready,
  output logic                     mem_write_en,
  output logic [31:0]              mem_write_address,
  output logic [31:0]              mem_write_data,
  output logic [31:0]              mem_read_address,
  input  logic [31:0]              mem_read_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_entry_t              entries [DEPTH];
  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;
  logic [CNT_W-1:0]          occ;
  logic                      push;
  logic                      pop;
  store_entry_t [DEPTH-1:0]  ordered;
  logic [DEPTH-1:0]          live;
  logic                      fwd_hit;
  logic [31:0]               fwd_data;

  // Status is forced to its reset view while rst is low, even before the first reset edge.
  assign empty        = !rst || (occ == '0);
  assign full         = rst && (occ == CNT_W'(DEPTH));
  assign count        = rst ? occ : '0;
  assign mem_write_en = !empty && mem_ready && rst;
  assign pop          = mem_write_en;
  assign st_ready     = rst && (!full || pop);
  assign push         = st_valid && st_ready;

  assign mem_write_address = entries[head].addr;
  assign mem_write_data    = entries[head].data;
  assign mem_read_address  = ld_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[tail] <= '{addr: st_addr, data: st_data};
  end

  // Rotate storage into age order from head; a store pushed this cycle is not yet visible.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ordered[i] = entries[head + PTR_W'(i)];
      live[i]    = CNT_W'(i) < occ;
    end
  end

  sb_forward_match #(.DEPTH(DEPTH)) u_match (
    .entries (ordered),
    .valid   (live),
    .addr    (ld_addr),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  assign ld_data = (fwd_hit && rst) ? fwd_data : mem_read_data;

endmodule
